// File: rtl/nasti_narrower_reader.sv
// nasti_narrower_reader: read-channel width converter from a wide NASTI master
// to a narrow NASTI slave. One master request becomes one slave burst; narrow
// beats are packed into wide R beats. One transaction is outstanding at a time.
module nasti_narrower_reader #(
  parameter int ID_WIDTH          = 2,
  parameter int ADDR_WIDTH        = 32,
  parameter int MASTER_DATA_WIDTH = 64,
  parameter int SLAVE_DATA_WIDTH  = 32,
  parameter int USER_WIDTH        = 1
) (
  input  logic                         clk,
  input  logic                         rstn,
  // master AR
  input  logic [ID_WIDTH-1:0]          master_ar_id,
  input  logic [ADDR_WIDTH-1:0]        master_ar_addr,
  input  logic [7:0]                   master_ar_len,
  input  logic [2:0]                   master_ar_size,
  input  logic [1:0]                   master_ar_burst,
  input  logic                         master_ar_lock,
  input  logic [3:0]                   master_ar_cache,
  input  logic [2:0]                   master_ar_prot,
  input  logic [3:0]                   master_ar_qos,
  input  logic [3:0]                   master_ar_region,
  input  logic [USER_WIDTH-1:0]        master_ar_user,
  input  logic                         master_ar_valid,
  output logic                         master_ar_ready,
  // master R
  output logic [ID_WIDTH-1:0]          master_r_id,
  output logic [MASTER_DATA_WIDTH-1:0] master_r_data,
  output logic [1:0]                   master_r_resp,
  output logic                         master_r_last,
  output logic [USER_WIDTH-1:0]        master_r_user,
  output logic                         master_r_valid,
  input  logic                         master_r_ready,
  // slave AR
  output logic [ID_WIDTH-1:0]          slave_ar_id,
  output logic [ADDR_WIDTH-1:0]        slave_ar_addr,
  output logic [7:0]                   slave_ar_len,
  output logic [2:0]                   slave_ar_size,
  output logic [1:0]                   slave_ar_burst,
  output logic                         slave_ar_lock,
  output logic [3:0]                   slave_ar_cache,
  output logic [2:0]                   slave_ar_prot,
  output logic [3:0]                   slave_ar_qos,
  output logic [3:0]                   slave_ar_region,
  output logic [USER_WIDTH-1:0]        slave_ar_user,
  output logic                         slave_ar_valid,
  input  logic                         slave_ar_ready,
  // slave R
  input  logic [ID_WIDTH-1:0]          slave_r_id,
  input  logic [SLAVE_DATA_WIDTH-1:0]  slave_r_data,
  input  logic [1:0]                   slave_r_resp,
  input  logic                         slave_r_last,
  input  logic [USER_WIDTH-1:0]        slave_r_user,
  input  logic                         slave_r_valid,
  output logic                         slave_r_ready
);

  localparam int MCS       = $clog2(MASTER_DATA_WIDTH / 8);
  localparam int SCS       = $clog2(SLAVE_DATA_WIDTH / 8);
  localparam int LANE_MASK = (1 << (MCS - SCS)) - 1;

  typedef enum logic [1:0] {S_IDLE, S_AR, S_R} state_t;

  state_t                   state, state_nxt;
  logic [ID_WIDTH-1:0]      id_q;
  logic [ADDR_WIDTH-1:0]    addr_q;
  logic [7:0]               len_q;
  logic [2:0]               size_q;
  logic [1:0]               burst_q;
  logic                     lock_q;
  logic [3:0]               cache_q, qos_q, region_q;
  logic [2:0]               prot_q;
  logic [USER_WIDTH-1:0]    user_q;
  logic [7:0]               r_cnt;
  logic [MASTER_DATA_WIDTH-1:0] buf_q;
  logic [1:0]               resp_acc;
  logic [MASTER_DATA_WIDTH-1:0] r_data_q;
  logic [1:0]               r_resp_q;
  logic                     r_last_q, r_valid_q;
  logic [USER_WIDTH-1:0]    r_user_q;

  logic                     ar_fire, r_fire, mr_fire;
  logic [ADDR_WIDTH-1:0]    size_mask, step;
  int                       lane;
  logic [MASTER_DATA_WIDTH-1:0] merged;
  logic [1:0]               resp_merged;
  logic                     at_end, beat_done;

  // slave_r_id carries no information: the captured id is returned instead
  logic unused_slave_r_id;
  assign unused_slave_r_id = ^slave_r_id;

  // Number of narrow beats minus one needed to cover the wide request.
  function automatic logic [7:0] narrow_len(input logic [ADDR_WIDTH-1:0] a,
                                            input logic [7:0] l,
                                            input logic [2:0] s);
    logic [2:0]            sh;
    logic [ADDR_WIDTH-1:0] off;
    if (s > 3'(SCS)) begin
      sh  = s - 3'(SCS);
      off = (a & ((ADDR_WIDTH'(1) << s) - ADDR_WIDTH'(1))) >> SCS;
      return 8'((16'(l) << sh) + (16'd1 << sh) - 16'(off) - 16'd1);
    end
    return l;
  endfunction

  assign ar_fire = master_ar_valid && master_ar_ready;
  assign r_fire  = slave_r_valid && slave_r_ready;
  assign mr_fire = r_valid_q && master_r_ready;

  // Beat bookkeeping: lane select, merged buffer and master-beat completion
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    size_mask   = (ADDR_WIDTH'(1) << size_q) - ADDR_WIDTH'(1);
    step        = (size_q > 3'(SCS)) ? ADDR_WIDTH'(SLAVE_DATA_WIDTH / 8)
                                     : (ADDR_WIDTH'(1) << size_q);
    lane        = int'((addr_q >> SCS) & ADDR_WIDTH'(LANE_MASK));
    merged      = buf_q;
    merged[lane*SLAVE_DATA_WIDTH +: SLAVE_DATA_WIDTH] = slave_r_data;
    resp_merged = (slave_r_resp > resp_acc) ? slave_r_resp : resp_acc;
    at_end      = (r_cnt == len_q);
    beat_done   = (((addr_q & size_mask) + step) > size_mask) || at_end;
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: sequential state uses non-blocking assignments to avoid ordering races.
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (master_ar_valid)                         state_nxt = S_AR;
      S_AR:   if (slave_ar_ready)                          state_nxt = S_R;
      S_R:    if (mr_fire && r_last_q)                     state_nxt = S_IDLE;
      default:                                             state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    master_ar_ready = (state == S_IDLE);
    slave_ar_valid  = (state == S_AR);
    slave_r_ready   = (state == S_R) && (!r_valid_q || master_r_ready);
  end

  // Request capture, beat packing and master R output stage
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      id_q <= '0; addr_q <= '0; len_q <= '0; size_q <= '0; burst_q <= '0;
      lock_q <= 1'b0; cache_q <= '0; prot_q <= '0; qos_q <= '0; region_q <= '0;
      user_q <= '0; r_cnt <= '0; buf_q <= '0; resp_acc <= '0;
      r_data_q <= '0; r_resp_q <= '0; r_last_q <= 1'b0; r_user_q <= '0;
      r_valid_q <= 1'b0;
    end else begin
      if (ar_fire) begin
        id_q     <= master_ar_id;
        addr_q   <= master_ar_addr;
        len_q    <= narrow_len(master_ar_addr, master_ar_len, master_ar_size);
        size_q   <= master_ar_size;
        burst_q  <= master_ar_burst;
        lock_q   <= master_ar_lock;
        cache_q  <= master_ar_cache;
        prot_q   <= master_ar_prot;
        qos_q    <= master_ar_qos;
        region_q <= master_ar_region;
        user_q   <= master_ar_user;
        r_cnt    <= '0;
        buf_q    <= '0;
        resp_acc <= '0;
        assert (master_ar_burst == 2'b01)
          else $fatal(1, "nasti_narrower_reader: only INCR bursts supported");
        assert (((32'd1 << master_ar_size) * (32'(master_ar_len) + 32'd1))
                <= 32'(32 * SLAVE_DATA_WIDTH))
          else $fatal(1, "nasti_narrower_reader: request too large");
      end else if (r_fire) begin
        addr_q <= (addr_q & ~(step - ADDR_WIDTH'(1))) + step;
        r_cnt  <= r_cnt + 8'd1;
        if (beat_done) begin
          buf_q    <= '0;
          resp_acc <= '0;
        end else begin
          buf_q    <= merged;
          resp_acc <= resp_merged;
        end
        assert (slave_r_last == at_end)
          else $fatal(1, "nasti_narrower_reader: slave_r_last out of place");
      end

      if (r_fire && beat_done) begin
        r_valid_q <= 1'b1;
        r_data_q  <= merged;
        r_resp_q  <= resp_merged;
        r_last_q  <= at_end;
        r_user_q  <= slave_r_user;
      end else if (mr_fire) begin
        r_valid_q <= 1'b0;
      end
    end
  end

  assign master_r_id     = id_q;
  assign master_r_data   = r_data_q;
  assign master_r_resp   = r_resp_q;
  assign master_r_last   = r_last_q;
  assign master_r_user   = r_user_q;
  assign master_r_valid  = r_valid_q;

  assign slave_ar_id     = id_q;
  assign slave_ar_addr   = addr_q;
  assign slave_ar_len    = len_q;
  assign slave_ar_size   = (size_q > 3'(SCS)) ? 3'(SCS) : size_q;
  assign slave_ar_burst  = burst_q;
  assign slave_ar_lock   = lock_q;
  assign slave_ar_cache  = cache_q;
  assign slave_ar_prot   = prot_q;
  assign slave_ar_qos    = qos_q;
  assign slave_ar_region = region_q;
  assign slave_ar_user   = user_q;

endmodule

// File: tb/tb_nasti_narrower_reader.sv
// tb_nasti_narrower_reader: directed scoreboard bench for the 64->32 read narrower.
module tb_nasti_narrower_reader;

  logic        clk, rstn;
  logic [1:0]  master_ar_id;
  logic [31:0] master_ar_addr;
  logic [7:0]  master_ar_len;
  logic [2:0]  master_ar_size;
  logic [1:0]  master_ar_burst;
  logic        master_ar_lock;
  logic [3:0]  master_ar_cache;
  logic [2:0]  master_ar_prot;
  logic [3:0]  master_ar_qos;
  logic [3:0]  master_ar_region;
  logic        master_ar_user;
  logic        master_ar_valid, master_ar_ready;
  logic [1:0]  master_r_id;
  logic [63:0] master_r_data;
  logic [1:0]  master_r_resp;
  logic        master_r_last, master_r_user, master_r_valid, master_r_ready;
  logic [1:0]  slave_ar_id;
  logic [31:0] slave_ar_addr;
  logic [7:0]  slave_ar_len;
  logic [2:0]  slave_ar_size;
  logic [1:0]  slave_ar_burst;
  logic        slave_ar_lock;
  logic [3:0]  slave_ar_cache;
  logic [2:0]  slave_ar_prot;
  logic [3:0]  slave_ar_qos;
  logic [3:0]  slave_ar_region;
  logic        slave_ar_user;
  logic        slave_ar_valid, slave_ar_ready;
  logic [1:0]  slave_r_id;
  logic [31:0] slave_r_data;
  logic [1:0]  slave_r_resp;
  logic        slave_r_last, slave_r_user, slave_r_valid, slave_r_ready;

  nasti_narrower_reader dut (
    .clk(clk), .rstn(rstn),
    .master_ar_id(master_ar_id), .master_ar_addr(master_ar_addr),
    .master_ar_len(master_ar_len), .master_ar_size(master_ar_size),
    .master_ar_burst(master_ar_burst), .master_ar_lock(master_ar_lock),
    .master_ar_cache(master_ar_cache), .master_ar_prot(master_ar_prot),
    .master_ar_qos(master_ar_qos), .master_ar_region(master_ar_region),
    .master_ar_user(master_ar_user), .master_ar_valid(master_ar_valid),
    .master_ar_ready(master_ar_ready),
    .master_r_id(master_r_id), .master_r_data(master_r_data),
    .master_r_resp(master_r_resp), .master_r_last(master_r_last),
    .master_r_user(master_r_user), .master_r_valid(master_r_valid),
    .master_r_ready(master_r_ready),
    .slave_ar_id(slave_ar_id), .slave_ar_addr(slave_ar_addr),
    .slave_ar_len(slave_ar_len), .slave_ar_size(slave_ar_size),
    .slave_ar_burst(slave_ar_burst), .slave_ar_lock(slave_ar_lock),
    .slave_ar_cache(slave_ar_cache), .slave_ar_prot(slave_ar_prot),
    .slave_ar_qos(slave_ar_qos), .slave_ar_region(slave_ar_region),
    .slave_ar_user(slave_ar_user), .slave_ar_valid(slave_ar_valid),
    .slave_ar_ready(slave_ar_ready),
    .slave_r_id(slave_r_id), .slave_r_data(slave_r_data),
    .slave_r_resp(slave_r_resp), .slave_r_last(slave_r_last),
    .slave_r_user(slave_r_user), .slave_r_valid(slave_r_valid),
    .slave_r_ready(slave_r_ready)
  );

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  id;
  } ar_exp_t;

  typedef struct {
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [1:0]  id;
    logic        user;
  } r_exp_t;

  ar_exp_t     ar_q[$];
  r_exp_t      r_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] beat_data[16];
  logic [1:0]  beat_resp[16];
  logic        bp_arm = 1'b0;
  int          hold = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic flag_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Master R ready: normally high; a stall of 5 cycles is armed on the next held beat
  always @(posedge clk) begin
    #1;
    if (bp_arm && master_r_valid) begin
      hold   = 5;
      bp_arm = 1'b0;
    end
    if (hold > 0) begin
      master_r_ready = 1'b0;
      hold--;
    end else begin
      master_r_ready = 1'b1;
    end
  end

  // Monitor: sample handshakes mid-cycle and compare against the scoreboard
  always @(negedge clk) begin
    if (rstn) begin
      if (slave_ar_valid && slave_ar_ready) begin
        if (ar_q.size() == 0) flag_fail("slave_ar unexpected request");
        else begin
          ar_exp_t e;
          e = ar_q.pop_front();
          check("slave_ar_addr", 64'(slave_ar_addr), 64'(e.addr));
          check("slave_ar_len",  64'(slave_ar_len),  64'(e.len));
          check("slave_ar_size", 64'(slave_ar_size), 64'(e.size));
          check("slave_ar_id",   64'(slave_ar_id),   64'(e.id));
          check("slave_ar_burst", 64'(slave_ar_burst), 64'd1);
        end
      end
      if (master_r_valid && master_r_ready) begin
        if (r_q.size() == 0) flag_fail("master_r unexpected beat");
        else begin
          r_exp_t e;
          e = r_q.pop_front();
          check("master_r_data", master_r_data, e.data);
          check("master_r_resp", 64'(master_r_resp), 64'(e.resp));
          check("master_r_last", 64'(master_r_last), 64'(e.last));
          check("master_r_id",   64'(master_r_id),   64'(e.id));
          check("master_r_user", 64'(master_r_user), 64'(e.user));
        end
      end
      if (master_r_valid && !master_r_ready)
        check("slave_r_ready_while_stalled", 64'(slave_r_ready), 64'd0);
    end
  end

  task automatic push_ar(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                         input logic [1:0] id);
    ar_exp_t e;
    e.addr = a; e.len = l; e.size = s; e.id = id;
    ar_q.push_back(e);
  endtask

  task automatic push_r(input logic [63:0] d, input logic [1:0] rs, input logic l,
                        input logic [1:0] id, input logic u);
    r_exp_t e;
    e.data = d; e.resp = rs; e.last = l; e.id = id; e.user = u;
    r_q.push_back(e);
  endtask

  // Issue one master AR; called and returns at posedge+1
  task automatic send_ar(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                         input logic [1:0] id);
    bit done = 0;
    master_ar_id = id; master_ar_addr = a; master_ar_len = l; master_ar_size = s;
    master_ar_burst = 2'b01; master_ar_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (master_ar_ready) begin done = 1; break; end
    end
    @(posedge clk); #1;
    master_ar_valid = 1'b0;
    if (!done) flag_fail("master_ar accept timeout");
  endtask

  // Drive n_send of the n_total slave beats from beat_data/beat_resp
  task automatic send_beats(input int n_total, input int n_send, input logic [1:0] id);
    for (int i = 0; i < n_send; i++) begin
      bit done = 0;
      slave_r_id    = id;
      slave_r_data  = beat_data[i];
      slave_r_resp  = beat_resp[i];
      slave_r_last  = (i == n_total - 1);
      slave_r_user  = i[0];
      slave_r_valid = 1'b1;
      for (int c = 0; c < 100; c++) begin
        @(negedge clk);
        if (slave_r_ready) begin done = 1; break; end
      end
      @(posedge clk); #1;
      if (!done) begin
        flag_fail("slave_r accept timeout");
        break;
      end
    end
    slave_r_valid = 1'b0;
    slave_r_last  = 1'b0;
  endtask

  task automatic wait_drain();
    bit done = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (r_q.size() == 0 && ar_q.size() == 0) begin done = 1; break; end
    end
    if (!done) flag_fail("scoreboard drain timeout");
    r_q.delete();
    ar_q.delete();
    @(posedge clk); #1;
  endtask

  initial begin
    rstn = 1'b0;
    master_ar_id = '0; master_ar_addr = '0; master_ar_len = '0; master_ar_size = '0;
    master_ar_burst = 2'b01; master_ar_lock = 1'b0; master_ar_cache = 4'h3;
    master_ar_prot = 3'h0; master_ar_qos = 4'h0; master_ar_region = 4'h0;
    master_ar_user = 1'b0; master_ar_valid = 1'b0; master_r_ready = 1'b1;
    slave_ar_ready = 1'b1; slave_r_id = '0; slave_r_data = '0; slave_r_resp = '0;
    slave_r_last = 1'b0; slave_r_user = 1'b0; slave_r_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin beat_data[i] = '0; beat_resp[i] = '0; end

    repeat (3) @(posedge clk);
    #1;
    check("reset_master_ar_ready", 64'(master_ar_ready), 64'd1);
    check("reset_slave_ar_valid",  64'(slave_ar_valid),  64'd0);
    check("reset_master_r_valid",  64'(master_r_valid),  64'd0);
    check("reset_slave_r_ready",   64'(slave_r_ready),   64'd0);
    check("reset_master_r_last",   64'(master_r_last),   64'd0);
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;

    // Aligned full-width read
    push_ar(32'h1000, 8'd1, 3'd2, 2'd1);
    push_r(64'h22222222_11111111, 2'b00, 1'b1, 2'd1, 1'b1);
    beat_data[0] = 32'h11111111; beat_data[1] = 32'h22222222;
    beat_resp[0] = 2'b00; beat_resp[1] = 2'b00;
    send_ar(32'h1000, 8'd0, 3'd3, 2'd1);
    send_beats(2, 2, 2'd1);
    wait_drain();

    // Unaligned start
    push_ar(32'h1004, 8'd2, 3'd2, 2'd2);
    push_r(64'hAAAA0001_00000000, 2'b00, 1'b0, 2'd2, 1'b0);
    push_r(64'hCCCC0003_BBBB0002, 2'b00, 1'b1, 2'd2, 1'b0);
    beat_data[0] = 32'hAAAA0001; beat_data[1] = 32'hBBBB0002; beat_data[2] = 32'hCCCC0003;
    beat_resp[2] = 2'b00;
    send_ar(32'h1004, 8'd1, 3'd3, 2'd2);
    send_beats(3, 3, 2'd2);
    wait_drain();

    // Narrow request
    push_ar(32'h1004, 8'd0, 3'd2, 2'd3);
    push_r(64'hDEADBEEF_00000000, 2'b00, 1'b1, 2'd3, 1'b0);
    beat_data[0] = 32'hDEADBEEF;
    send_ar(32'h1004, 8'd0, 3'd2, 2'd3);
    send_beats(1, 1, 2'd3);
    wait_drain();

    // Backpressure on a len 3 size 3 burst
    push_ar(32'h3000, 8'd7, 3'd2, 2'd0);
    for (int i = 0; i < 8; i++) begin
      beat_data[i] = 32'hD0D0_0000 | 32'(i);
      beat_resp[i] = 2'b00;
    end
    push_r(64'hD0D00001_D0D00000, 2'b00, 1'b0, 2'd0, 1'b1);
    push_r(64'hD0D00003_D0D00002, 2'b00, 1'b0, 2'd0, 1'b1);
    push_r(64'hD0D00005_D0D00004, 2'b00, 1'b0, 2'd0, 1'b1);
    push_r(64'hD0D00007_D0D00006, 2'b00, 1'b1, 2'd0, 1'b1);
    send_ar(32'h3000, 8'd3, 3'd3, 2'd0);
    bp_arm = 1'b1;
    send_beats(8, 8, 2'd0);
    wait_drain();

    // Error response on the second narrow beat
    push_ar(32'h1000, 8'd1, 3'd2, 2'd1);
    push_r(64'h22222222_11111111, 2'b10, 1'b1, 2'd1, 1'b1);
    beat_data[0] = 32'h11111111; beat_data[1] = 32'h22222222;
    beat_resp[0] = 2'b00; beat_resp[1] = 2'b10;
    send_ar(32'h1000, 8'd0, 3'd3, 2'd1);
    send_beats(2, 2, 2'd1);
    wait_drain();

    // Reset after the first slave beat: partial data is dropped
    push_ar(32'h4000, 8'd1, 3'd2, 2'd2);
    beat_data[0] = 32'h55555555; beat_resp[0] = 2'b00;
    send_ar(32'h4000, 8'd0, 3'd3, 2'd2);
    send_beats(2, 1, 2'd2);
    rstn = 1'b0;
    #1;
    check("rst_mid_master_r_valid", 64'(master_r_valid), 64'd0);
    check("rst_mid_master_ar_ready", 64'(master_ar_ready), 64'd1);
    check("rst_mid_slave_ar_valid", 64'(slave_ar_valid), 64'd0);
    check("rst_mid_slave_r_ready", 64'(slave_r_ready), 64'd0);
    check("rst_mid_ar_consumed", 64'(ar_q.size()), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;

    push_ar(32'h4008, 8'd1, 3'd2, 2'd3);
    push_r(64'h88888888_77777777, 2'b00, 1'b1, 2'd3, 1'b1);
    beat_data[0] = 32'h77777777; beat_data[1] = 32'h88888888;
    beat_resp[0] = 2'b00; beat_resp[1] = 2'b00;
    send_ar(32'h4008, 8'd0, 3'd3, 2'd3);
    send_beats(2, 2, 2'd3);
    wait_drain();

    repeat (3) @(posedge clk);
    #1;
    check("final_master_ar_ready", 64'(master_ar_ready), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nasti_narrower_reader.md
# nasti_narrower_reader

Read-channel counterpart of the NASTI narrower: it converts AR/R traffic from a wide master port (MASTER_DATA_WIDTH) to a narrower slave port (SLAVE_DATA_WIDTH). It sits between a wide NASTI master (e.g. the cache/memory interconnect) and a narrow peripheral or memory slave. Each master request becomes one slave burst of SLAVE_DATA_WIDTH-sized beats. The block packs the returning narrow beats into wide master R beats and keeps one transaction outstanding at a time.

## Interface
- ID_WIDTH, 2, NASTI ID width
- ADDR_WIDTH, 32, address width
- MASTER_DATA_WIDTH, 64, master-side data width, a power of two, ≥ SLAVE_DATA_WIDTH
- SLAVE_DATA_WIDTH, 32, slave-side data width, a power of two
- USER_WIDTH, 1, USER field width
- Derived constants:
  - MCS = clog2(MASTER_DATA_WIDTH/8)
  - SCS = clog2(SLAVE_DATA_WIDTH/8)
- clk  in  1  clock; single clock domain
- rstn  in  1  reset; asynchronous, active-low
- master_ar_{id,addr,len,size,burst,lock,cache,prot,qos,region,user,valid}  in  standard NASTI widths  master read request
- master_ar_ready  out  1  request accept
- master_r_{id,data,resp,last,user,valid}  out  ID_WIDTH / MASTER_DATA_WIDTH / 2 / 1 / USER_WIDTH / 1  wide read data
- master_r_ready  in  1
- slave_ar_{id,addr,len,size,burst,lock,cache,prot,qos,region,user,valid}  out  standard NASTI widths  narrow request
- slave_ar_ready  in  1
- slave_r_{id,data,resp,last,user,valid}  in  ID_WIDTH / SLAVE_DATA_WIDTH / 2 / 1 / USER_WIDTH / 1
- slave_r_ready  out  1

## Operation
- **State machine:** S_IDLE → S_AR → S_R → S_IDLE.
  - S_IDLE → S_AR on the master AR handshake.
  - S_AR → S_R on the slave AR handshake.
  - S_R → S_IDLE on the master R handshake with master_r_last.
- **Request capture:** the request is registered on the master AR handshake.
  - The running address is loaded with master_ar_addr.
  - The slave beat counter r_cnt is cleared.
  - The data buffer is cleared to zero.
- **Slave request fields:**
  - ratio = size>SCS ? 2^(size−SCS) : 1
  - step = size>SCS ? SLAVE_DATA_WIDTH/8 : 2^size
  - slave_ar_size = min(size, SCS)
  - slave_ar_len = ratio>1 ? (len<<(size−SCS)) + ratio − addr[size−1:SCS] − 1 : len
  - All other slave AR fields copy the captured request.
- **Accepted slave beat:**
  - The beat's data is written into buffer lane addr[MCS−1:SCS]; other lanes are untouched.
  - resp_acc becomes the numeric max of resp_acc and slave_r_resp.
  - The address advances: addr ← (addr & ~(step−1)) + step.
  - r_cnt increments.
- **Master beat completion:** a slave beat completes a master beat when either of these holds:
  - (addr & (2^size−1)) + step ≥ 2^size, evaluated on the pre-increment address;
  - r_cnt == slave_ar_len.
- **On master beat completion:**
  - The buffer, resp_acc and last (r_cnt == slave_ar_len) are registered into the master R output stage.
  - master_r_valid rises.
  - Buffer and resp_acc are cleared. A slave beat accepted in the same cycle writes into the cleared buffer.
- **Master R fields:**
  - master_r_id = captured id.
  - master_r_user = user of the completing slave beat.
  - Lanes not filled in the current master beat read as zero.
- **Assertions (simulation $fatal):**
  - burst ≠ INCR.
  - (1<<size)*(len+1) > 32*SLAVE_DATA_WIDTH.
  - slave_r_last ≠ (r_cnt == slave_ar_len) on any accepted slave beat.

## Timing
- **Reset:** all state is cleared asynchronously.
  - State goes to S_IDLE and r_cnt to 0.
  - master_ar_ready=1; slave_ar_valid=0.
  - master_r_valid=0; slave_r_ready=0; master_r_last=0.
- **Reset mid-transaction:** partial data is discarded and no master R beat is emitted.
- **Channel handshakes:**
  - master_ar_ready = (state==S_IDLE).
  - slave_ar_valid = (state==S_AR). The slave request is issued one cycle after master acceptance at the earliest.
  - slave_r_ready = (state==S_R) && (!master_r_valid || master_r_ready). This gives full throughput: a held master beat drains in the same cycle a new slave beat is accepted.
- **Latency:** master_r_valid asserts the cycle after the completing slave beat's handshake. It is held stable with its data until master_r_ready.
- **Return to idle:** master_ar_ready reasserts the cycle after the final master R handshake.
- **Ignored inputs:** master AR is never accepted outside S_IDLE. Slave R input is ignored outside S_R.

## Test plan
- **Aligned full-width read:** 64→32, AR addr 0x1000, size 3, len 0.
  - Required: slave_ar len 1, size 2, addr 0x1000.
  - Slave beats 0x11111111, 0x22222222 → one master beat, data 0x22222222_11111111, last=1, resp 0.
- **Unaligned start:** AR addr 0x1004, size 3, len 1.
  - Required: slave_ar len 2.
  - Slave beats A, B, C → master beat 1 = {A, 0}, last=0; master beat 2 = {C, B}, last=1.
- **Narrow request:** AR addr 0x1004, size 2, len 0.
  - Required: slave_ar size 2, len 0.
  - Slave beat 0xDEADBEEF → master data 0xDEADBEEF_00000000, last=1.
- **Backpressure:** hold master_r_ready low for 5 cycles during a len 3 size 3 burst.
  - Required: slave_r_ready low while a master beat is held; no data lost or duplicated; 4 master beats delivered in order.
- **Error response:** in the aligned case, the second slave beat carries resp=2'b10.
  - Required: master beat resp = 2'b10.
- **Reset mid-burst:** assert rstn low after the first slave beat.
  - Required: master_r_valid=0 and master_ar_ready=1 immediately.
  - After release, a new request completes normally.
